run_seq_tx: RTL and testbench

//   Serial run-length transmitter: the generator side of the N-consecutive-1s/0s detector.

---
 rtl/run_seq_tx.sv | 151 +++++++++++++++
 tb/tb_run_seq_tx.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_seq_tx.sv
// Serial run-length transmitter.
// Run descriptors {bit, length} are queued in a small FIFO and replayed as one bit per clock
// on w. Back-to-back runs are emitted without gap cycles; zero-length runs are discarded.
module run_seq_tx #(
    parameter int unsigned LEN_W = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             in_bit_i,
    input  logic [LEN_W-1:0] in_len_i,
    input  logic             flush_i,
    output logic             w_o,
    output logic             w_valid_o,
    output logic             run_end_o,
    output logic             busy_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LEN_W-1:0] CntOne = LEN_W'(1);
    localparam logic [AW:0] PtrOne = (AW + 1)'(1);

    typedef enum logic [0:0] {
        StIdle,
        StSend
    } state_e;

    // FIFO storage: each entry is {bit, len}
    logic [LEN_W:0] mem_q [DEPTH];
    logic [AW:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]    rd_ptr_q, rd_ptr_d;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             bit_q, bit_d;

    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic [LEN_W:0]   head;
    logic             head_bit;
    logic [LEN_W-1:0] head_len;

    // FIFO status and head-of-queue decode
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        head       = mem_q[rd_ptr_q[AW-1:0]];
        head_bit   = head[LEN_W];
        head_len   = head[LEN_W-1:0];
        // flush wins over a same-edge push, so the offered descriptor is dropped
        push       = in_valid_i && !fifo_full && !flush_i;
    end

    // Serializer next-state: loads a new run from the FIFO head when idle or on the last bit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        pop     = 1'b0;
        if (flush_i) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                        if (head_len != '0) begin
                            state_d = StSend;
                            cnt_d   = head_len;
                            bit_d   = head_bit;
                        end
                    end
                end
                StSend: begin
                    cnt_d = cnt_q - CntOne;
                    if (cnt_q == CntOne) begin
                        if (!fifo_empty) begin
                            pop = 1'b1;
                            if (head_len != '0) begin
                                // chain straight into the next run, no gap cycle
                                cnt_d = head_len;
                                bit_d = head_bit;
                            end else begin
                                state_d = StIdle;
                            end
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // FIFO pointer next-state; flush empties the queue by catching the read pointer up
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
        end else if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
    end

    // State, counter and pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bit_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // FIFO storage write; contents are don't-care until the pointers cover them
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {in_bit_i, in_len_i};
        end
    end

    // Outputs; bit_q only changes on a run load, so w holds the last sent bit while idle
    always_comb begin
        in_ready_o = !fifo_full;
        w_o        = bit_q;
        w_valid_o  = (state_q == StSend);
        run_end_o  = (state_q == StSend) && (cnt_q == CntOne);
        busy_o     = (state_q == StSend) || !fifo_empty;
    end

endmodule

// File: tb/tb_run_seq_tx.sv
// Bench for run_seq_tx: directed scenarios plus a randomized run against a queue-based model.
module tb_run_seq_tx;

    localparam int unsigned LEN_W = 4;
    localparam int unsigned DEPTH = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             in_bit;
    logic [LEN_W-1:0] in_len;
    logic             flush;
    logic             w;
    logic             w_valid;
    logic             run_end;
    logic             busy;

    int tests_run;
    int tests_failed;

    // Reference model state: pending descriptors and the run currently on the wire
    bit m_q_bit[$];
    int m_q_len[$];
    int m_rem;
    bit m_cur;

    run_seq_tx #(
        .LEN_W(LEN_W),
        .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid_i(in_valid),
        .in_ready_o(in_ready),
        .in_bit_i  (in_bit),
        .in_len_i  (in_len),
        .flush_i   (flush),
        .w_o       (w),
        .w_valid_o (w_valid),
        .run_end_o (run_end),
        .busy_o    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tests_run++;
        if (w !== 1'b0) begin
            $display("FAIL reset_w: got %b expected 0", w);
            tests_failed++;
        end
        tests_run++;
        if (w_valid !== 1'b0) begin
            $display("FAIL reset_w_valid: got %b expected 0", w_valid);
            tests_failed++;
        end
        tests_run++;
        if (run_end !== 1'b0) begin
            $display("FAIL reset_run_end: got %b expected 0", run_end);
            tests_failed++;
        end
        tests_run++;
        if (busy !== 1'b0) begin
            $display("FAIL reset_busy: got %b expected 0", busy);
            tests_failed++;
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
            tests_failed++;
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_run();
        logic exp_v;
        logic exp_e;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        in_len   = 4'd3;
        tick();
        in_valid = 1'b0;
        tests_run++;
        if (w_valid !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL single_queued: got v=%b busy=%b expected v=0 busy=1", w_valid, busy);
            tests_failed++;
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_v = (i < 3);
            exp_e = (i == 2);
            tests_run++;
            if (w_valid !== exp_v || w !== 1'b1 || run_end !== exp_e) begin
                $display("FAIL single_run[%0d]: got v=%b w=%b end=%b expected v=%b w=1 end=%b",
                         i, w_valid, w, run_end, exp_v, exp_e);
                tests_failed++;
            end
        end
        tests_run++;
        if (busy !== 1'b0) begin
            $display("FAIL single_idle_busy: got %b expected 0", busy);
            tests_failed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_w_vec;
        logic       exp_v;
        logic       exp_e;
        exp_w_vec = 6'b000011;
        in_valid  = 1'b1;
        in_bit    = 1'b1;
        in_len    = 4'd2;
        tick();
        in_bit    = 1'b0;
        in_len    = 4'd3;
        tick();
        in_valid  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            exp_v = (i < 5);
            exp_e = (i == 1) || (i == 4);
            tests_run++;
            if (w_valid !== exp_v || w !== exp_w_vec[i] || run_end !== exp_e) begin
                $display("FAIL back_to_back[%0d]: got v=%b w=%b end=%b expected v=%b w=%b end=%b",
                         i, w_valid, w, run_end, exp_v, exp_w_vec[i], exp_e);
                tests_failed++;
            end
            tick();
        end
    endtask

    task automatic test_full();
        logic exp_v, exp_w, exp_e, exp_r, exp_b;
        in_valid = 1'b1;
        in_bit   = 1'b0;
        in_len   = 4'd15;
        tick();
        in_bit   = 1'b1;
        in_len   = 4'd1;
        for (int i = 0; i < 22; i++) begin
            tick();
            exp_v = (i < 19);
            exp_w = (i >= 15);
            exp_e = (i >= 14) && (i <= 18);
            exp_r = !((i >= 3) && (i <= 14));
            exp_b = (i < 19);
            tests_run++;
            if (w_valid !== exp_v || w !== exp_w || run_end !== exp_e || in_ready !== exp_r ||
                busy !== exp_b) begin
                $display("FAIL full[%0d]: got v=%b w=%b end=%b rdy=%b busy=%b expected v=%b w=%b end=%b rdy=%b busy=%b",
                         i, w_valid, w, run_end, in_ready, busy, exp_v, exp_w, exp_e, exp_r, exp_b);
                tests_failed++;
            end
            if (i == 5) begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_zero_len();
        logic exp_v, exp_w, exp_e, exp_b;
        int   ends;
        ends     = 0;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        in_len   = 4'd0;
        tick();
        in_bit   = 1'b0;
        in_len   = 4'd2;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            // w still holds the trailing 1 of the previous scenario during the discard cycle
            exp_v = (i == 1) || (i == 2);
            exp_w = (i == 0);
            exp_e = (i == 2);
            exp_b = (i < 3);
            if (run_end === 1'b1) begin
                ends++;
            end
            tests_run++;
            if (w_valid !== exp_v || w !== exp_w || run_end !== exp_e || busy !== exp_b) begin
                $display("FAIL zero_len[%0d]: got v=%b w=%b end=%b busy=%b expected v=%b w=%b end=%b busy=%b",
                         i, w_valid, w, run_end, busy, exp_v, exp_w, exp_e, exp_b);
                tests_failed++;
            end
            tick();
        end
        tests_run++;
        if (ends != 1) begin
            $display("FAIL zero_len_end_count: got %0d expected 1", ends);
            tests_failed++;
        end
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1;
        in_bit   = 1'b1;
        in_len   = 4'd8;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        tests_run++;
        if (w_valid !== 1'b1 || w !== 1'b1) begin
            $display("FAIL areset_mid_run: got v=%b w=%b expected v=1 w=1", w_valid, w);
            tests_failed++;
        end
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (w !== 1'b0 || w_valid !== 1'b0 || run_end !== 1'b0 || busy !== 1'b0 ||
            in_ready !== 1'b1) begin
            $display("FAIL areset_immediate: got w=%b v=%b end=%b busy=%b rdy=%b expected 0 0 0 0 1",
                     w, w_valid, run_end, busy, in_ready);
            tests_failed++;
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        in_valid = 1'b1;
        in_bit   = 1'b0;
        in_len   = 4'd1;
        tick();
        in_valid = 1'b0;
        tests_run++;
        if (w_valid !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL areset_requeue: got v=%b busy=%b expected v=0 busy=1", w_valid, busy);
            tests_failed++;
        end
        tick();
        tests_run++;
        if (w_valid !== 1'b1 || w !== 1'b0 || run_end !== 1'b1) begin
            $display("FAIL areset_rerun: got v=%b w=%b end=%b expected v=1 w=0 end=1",
                     w_valid, w, run_end);
            tests_failed++;
        end
        tick();
        tests_run++;
        if (w_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL areset_done: got v=%b busy=%b expected v=0 busy=0", w_valid, busy);
            tests_failed++;
        end
    endtask

    task automatic test_flush();
        in_valid = 1'b1;
        in_bit   = 1'b1;
        in_len   = 4'd15;
        tick();
        in_bit   = 1'b0;
        in_len   = 4'd2;
        tick();
        in_bit   = 1'b1;
        in_len   = 4'd3;
        tick();
        in_bit   = 1'b0;
        in_len   = 4'd4;
        tick();
        tests_run++;
        if (w_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b1) begin
            $display("FAIL flush_setup: got v=%b busy=%b rdy=%b expected 1 1 1",
                     w_valid, busy, in_ready);
            tests_failed++;
        end
        flush    = 1'b1;
        in_bit   = 1'b1;
        in_len   = 4'd5;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        tests_run++;
        if (w_valid !== 1'b0 || busy !== 1'b0 || run_end !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL flush_now: got v=%b busy=%b end=%b rdy=%b expected 0 0 0 1",
                     w_valid, busy, run_end, in_ready);
            tests_failed++;
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if (w_valid !== 1'b0 || busy !== 1'b0) begin
                $display("FAIL flush_dropped[%0d]: got v=%b busy=%b expected v=0 busy=0",
                         i, w_valid, busy);
                tests_failed++;
            end
        end
    endtask

    // Advance the model across one clock edge with the given inputs
    task automatic model_step(input bit v, input bit b, input int l, input bit f);
        bit acc;
        if (f) begin
            m_q_bit.delete();
            m_q_len.delete();
            m_rem = 0;
        end else begin
            acc = v && (m_q_len.size() < DEPTH);
            if (m_q_len.size() > 0 && m_rem <= 1) begin
                if (m_q_len[0] > 0) begin
                    m_rem = m_q_len[0];
                    m_cur = m_q_bit[0];
                end else begin
                    m_rem = 0;
                end
                void'(m_q_bit.pop_front());
                void'(m_q_len.pop_front());
            end else if (m_rem > 0) begin
                m_rem = m_rem - 1;
            end
            if (acc) begin
                m_q_bit.push_back(b);
                m_q_len.push_back(l);
            end
        end
    endtask

    task automatic test_random();
        logic exp_v, exp_w, exp_e, exp_r, exp_b;
        bit   v, b, f;
        int   l;
        rst = 1'b1;
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        m_q_bit.delete();
        m_q_len.delete();
        m_rem = 0;
        m_cur = 1'b0;
        for (int c = 0; c < 800; c++) begin
            exp_v = (m_rem > 0);
            exp_w = m_cur;
            exp_e = (m_rem == 1);
            exp_r = (m_q_len.size() < DEPTH);
            exp_b = (m_rem > 0) || (m_q_len.size() > 0);
            tests_run++;
            if (w_valid !== exp_v || w !== exp_w || run_end !== exp_e || in_ready !== exp_r ||
                busy !== exp_b) begin
                $display("FAIL random[%0d]: got v=%b w=%b end=%b rdy=%b busy=%b expected v=%b w=%b end=%b rdy=%b busy=%b",
                         c, w_valid, w, run_end, in_ready, busy, exp_v, exp_w, exp_e, exp_r, exp_b);
                tests_failed++;
            end
            v = ($urandom_range(0, 9) < 6);
            b = $urandom_range(0, 1) == 1;
            l = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                             : int'($urandom_range(0, 3));
            f = ($urandom_range(0, 39) == 0);
            in_valid = v;
            in_bit   = b;
            in_len   = LEN_W'(l);
            flush    = f;
            model_step(v, b, l, f);
            tick();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_bit       = 1'b0;
        in_len       = '0;
        flush        = 1'b0;
        test_reset();
        test_single_run();
        test_back_to_back();
        test_full();
        test_zero_len();
        test_async_reset();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
